wbu_arb: RTL

- Write-port arbiter for the single GPR write port.
- Several writeback requesters (ALU/LSU/CSR, MUL-DIV) each present a register write with a valid/ready handshake.
- Grants one per cycle, round-robin, and drives a registered write to the GPR file one cycle later.
- Replaces the direct writeback drive of the register file once multi-cycle units are added.

---
 rtl/wbu_arb.sv | 110 +++++++++++
 1 files changed

// File: rtl/wbu_arb.sv
// wbu_arb: round-robin arbiter for the single GPR write port.
// Requesters present (id, data) with valid/ready; one is granted per cycle
// and its write is registered onto o_wbu_gpr_wr_* the following cycle.
// Writes to x0 are consumed but suppressed.
// Optional: define WBU_ARB_PERF_EN to add o_conflict_cnt, a saturating
// count of cycles where two or more requesters competed.

`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0
`endif

module wbu_arb #(
  parameter int NUM_REQ = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_hold,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [NUM_REQ*`GPRS_WIDTH-1:0]  i_req_gpr_id,
  input  logic [NUM_REQ*`DATA_WIDTH-1:0]  i_req_data,
  output logic                            o_wbu_gpr_wr_en,
  output logic [`GPRS_WIDTH-1:0]          o_wbu_gpr_wr_id,
  output logic [`DATA_WIDTH-1:0]          o_wbu_gpr_wr_data,
`ifdef WBU_ARB_PERF_EN
  output logic [31:0]                     o_conflict_cnt,
`endif
  output logic                            o_busy
);

  localparam int PTR_WIDTH = $clog2(NUM_REQ);

  logic [PTR_WIDTH-1:0]   ptr;
  logic [PTR_WIDTH-1:0]   gnt_idx;
  logic                   any_vld;
  logic                   gnt;
  logic [`GPRS_WIDTH-1:0] gnt_id;
  logic [`DATA_WIDTH-1:0] gnt_data;

  // Rotating priority scan: walk offsets high to low so the smallest
  // offset from ptr is the one left standing.
  always_comb begin
    int s;
    any_vld = 1'b0;
    gnt_idx = '0;
    s       = 0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      s = int'(ptr) + i;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (i_req_valid[s]) begin
        any_vld = 1'b1;
        gnt_idx = s[PTR_WIDTH-1:0];
      end
    end
  end

  assign gnt      = any_vld && !i_hold && !i_rst;
  assign gnt_id   = i_req_gpr_id[gnt_idx*`GPRS_WIDTH +: `GPRS_WIDTH];
  assign gnt_data = i_req_data[gnt_idx*`DATA_WIDTH +: `DATA_WIDTH];

  // One-hot ready from the granted index; no dependence on id/data.
  always_comb begin
    o_req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++)
      o_req_ready[k] = gnt && (gnt_idx == PTR_WIDTH'(k));
  end

  assign o_busy = |(i_req_valid & ~o_req_ready);

  // Pointer moves past the winner; hold and idle cycles leave it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      ptr <= '0;
    else if (gnt)
      ptr <= (gnt_idx == PTR_WIDTH'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  // Output register: one-cycle write pulse; x0 writes are squashed to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || !gnt || gnt_id == '0) begin
      o_wbu_gpr_wr_en   <= 1'b0;
      o_wbu_gpr_wr_id   <= '0;
      o_wbu_gpr_wr_data <= `DATA_ZERO;
    end else begin
      o_wbu_gpr_wr_en   <= 1'b1;
      o_wbu_gpr_wr_id   <= gnt_id;
      o_wbu_gpr_wr_data <= gnt_data;
    end
  end

`ifdef WBU_ARB_PERF_EN
  logic conflict;
  assign conflict = !i_hold && ($countones(i_req_valid) >= 2);

  // Saturating count of contended cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_conflict_cnt <= '0;
    else if (conflict && o_conflict_cnt != 32'hFFFF_FFFF)
      o_conflict_cnt <= o_conflict_cnt + 32'd1;
  end
`endif

endmodule
